// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: debounces start/pause/clear (and lap when STOPWATCH_LAP_EN is defined), runs IDLE/RUN/PAUSED, strobes the counter.
// Latency: raw button edge -> press pulse 2+DB_CYCLES+1 cycles, press -> state/cnt_clr 1 cycle; first cnt_tick TICK_DIV cycles after entering RUN.
// Backpressure: none; cnt_tick/cnt_clr are fire-and-forget single-cycle strobes the counter must accept.
module stopwatch_ctrl #(
    parameter int TICK_DIV  = 50000000,
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_start,
    input  logic             btn_pause,
    input  logic             btn_clear,
    input  logic             btn_lap,
    input  logic [CNT_W-1:0] cnt_val,
    output logic             cnt_tick,
    output logic             cnt_clr,
    output logic             running,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] lap_val
);

    localparam int PW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;

    // Button indices into the conditioned press vector.
    localparam int B_START = 0;
    localparam int B_PAUSE = 1;
    localparam int B_CLEAR = 2;
`ifdef STOPWATCH_LAP_EN
    localparam int B_LAP   = 3;
    localparam int NB      = 4;
`else
    localparam int NB      = 3;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_PAUSED = 2'b10
    } state_t;

    state_t        st;
    logic [PW-1:0] presc;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] press;

`ifdef STOPWATCH_LAP_EN
    assign btn_raw = {btn_lap, btn_clear, btn_pause, btn_start};
`else
    assign btn_raw = {btn_clear, btn_pause, btn_start};
`endif

    for (genvar i = 0; i < NB; i++) begin : g_btn
        logic            sync1;
        logic            sync2;
        logic            lvl;
        logic            lvl_d;
        logic            prs;
        logic [DB_W-1:0] db_cnt;

        // Synchronise, debounce, and turn the debounced rising edge into a one-cycle press.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync1  <= 1'b0;
                sync2  <= 1'b0;
                lvl    <= 1'b0;
                lvl_d  <= 1'b0;
                prs    <= 1'b0;
                db_cnt <= '0;
            end else begin
                sync1 <= btn_raw[i];
                sync2 <= sync1;
                if (sync2 == lvl) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
                    // Level has disagreed for DB_CYCLES consecutive cycles: accept it.
                    lvl    <= sync2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
                lvl_d <= lvl;
                prs   <= lvl & ~lvl_d;
            end
        end

        assign press[i] = prs;
    end

    // Sequencer: state, running flag, prescaler and the two counter strobes share one register stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st       <= S_IDLE;
            running  <= 1'b0;
            cnt_tick <= 1'b0;
            cnt_clr  <= 1'b0;
            presc    <= '0;
        end else begin
            cnt_tick <= 1'b0;
            cnt_clr  <= 1'b0;
            if (press[B_CLEAR]) begin
                // Clear wins over everything; any tick due this cycle is dropped.
                st      <= S_IDLE;
                running <= 1'b0;
                cnt_clr <= 1'b1;
                presc   <= '0;
            end else begin
                case (st)
                    S_RUN: begin
                        if (presc == PW'(TICK_DIV - 1)) begin
                            presc    <= '0;
                            cnt_tick <= 1'b1;
                        end else begin
                            presc <= presc + 1'b1;
                        end
                        if (press[B_PAUSE]) begin
                            st      <= S_PAUSED;
                            running <= 1'b0;
                        end
                    end
                    S_PAUSED: begin
                        // Prescaler holds so a resume finishes the interrupted interval.
                        if (press[B_START]) begin
                            st      <= S_RUN;
                            running <= 1'b1;
                        end
                    end
                    default: begin
                        // IDLE and the unused encoding behave identically.
                        presc <= '0;
                        if (press[B_START]) begin
                            st      <= S_RUN;
                            running <= 1'b1;
                        end else begin
                            st      <= S_IDLE;
                            running <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign state = st;

`ifdef STOPWATCH_LAP_EN
    logic             lap_hold;
    logic [CNT_W-1:0] lap_q;
    logic             lap_ok;

    assign lap_ok = press[B_LAP] && (st == S_RUN || st == S_PAUSED);

    // Lap display: tracks the counter, freezes on the first lap press, resumes on the second.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_hold <= 1'b0;
            lap_q    <= '0;
        end else if (press[B_CLEAR]) begin
            lap_hold <= 1'b0;
            lap_q    <= '0;
        end else begin
            if (lap_ok) begin
                lap_hold <= ~lap_hold;
            end
            if (!lap_hold || lap_ok) begin
                lap_q <= cnt_val;
            end
        end
    end

    assign lap_val = lap_q;
`else
    logic unused_lap;
    assign unused_lap = btn_lap;
    assign lap_val    = cnt_val;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, DB_CYCLES=3, CNT_W=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Raw edge after edge E gives press after E+6 and state/cnt_clr after E+7.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_start;
    logic       btn_pause;
    logic       btn_clear;
    logic       btn_lap;
    logic [3:0] cnt_val;
    logic       cnt_tick;
    logic       cnt_clr;
    logic       running;
    logic [1:0] state;
    logic [3:0] lap_val;

    int n_checks = 0;
    int n_fail   = 0;

    stopwatch_ctrl #(.TICK_DIV(4), .DB_CYCLES(3), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_pause (btn_pause),
        .btn_clear (btn_clear),
        .btn_lap   (btn_lap),
        .cnt_val   (cnt_val),
        .cnt_tick  (cnt_tick),
        .cnt_clr   (cnt_clr),
        .running   (running),
        .state     (state),
        .lap_val   (lap_val)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance until a cycle with cnt_tick high; bounded.
    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            step(1);
            n++;
        end while (cnt_tick !== 1'b1 && n < 12);
        n_checks++;
        if (cnt_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_tick: cnt_tick=%b after %0d cycles, want 1", cnt_tick, n);
        end
    endtask

    task automatic test_reset();
        n_checks += 4;
        if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state got %b want 00", state); end
        if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running got %b want 0", running); end
        if (cnt_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b want 0", cnt_tick); end
        if (cnt_clr !== 1'b0) begin n_fail++; $display("FAIL reset_clr got %b want 0", cnt_clr); end
        n_checks++;
`ifdef STOPWATCH_LAP_EN
        if (lap_val !== 4'd0) begin n_fail++; $display("FAIL reset_lap got %0d want 0", lap_val); end
`else
        if (lap_val !== 4'd5) begin n_fail++; $display("FAIL reset_lap got %0d want 5", lap_val); end
`endif
    endtask

    task automatic test_start();
        logic [1:0] exp_st;
        logic       exp_tk;
        btn_start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            exp_st = (k >= 7) ? 2'b01 : 2'b00;
            exp_tk = (k >= 11) && ((k - 11) % 4 == 0);
            n_checks += 3;
            if (state !== exp_st) begin n_fail++; $display("FAIL start_state k=%0d got %b want %b", k, state, exp_st); end
            if (running !== exp_st[0]) begin n_fail++; $display("FAIL start_running k=%0d got %b want %b", k, running, exp_st[0]); end
            if (cnt_tick !== exp_tk) begin n_fail++; $display("FAIL start_tick k=%0d got %b want %b", k, cnt_tick, exp_tk); end
        end
        btn_start = 1'b0;
    endtask

    task automatic test_pause_glitch();
        logic exp_tk;
        wait_tick();
        btn_pause = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            if (k == 2) btn_pause = 1'b0;
            exp_tk = (k % 4 == 0);
            n_checks += 2;
            if (state !== 2'b01) begin n_fail++; $display("FAIL glitch_state k=%0d got %b want 01", k, state); end
            if (cnt_tick !== exp_tk) begin n_fail++; $display("FAIL glitch_tick k=%0d got %b want %b", k, cnt_tick, exp_tk); end
        end
    endtask

    task automatic test_pause_resume();
        logic [1:0] exp_st;
        logic       exp_tk;
        wait_tick();
        for (int k = 1; k <= 34; k++) begin
            step(1);
            if (k == 3)  btn_pause = 1'b1;
            if (k == 12) btn_pause = 1'b0;
            if (k == 20) btn_start = 1'b1;
            if (k == 30) btn_start = 1'b0;
            exp_st = (k < 10) ? 2'b01 : (k < 27) ? 2'b10 : 2'b01;
            exp_tk = (k == 4) || (k == 8) || (k == 29) || (k == 33);
            n_checks += 3;
            if (state !== exp_st) begin n_fail++; $display("FAIL resume_state k=%0d got %b want %b", k, state, exp_st); end
            if (running !== (exp_st == 2'b01)) begin n_fail++; $display("FAIL resume_running k=%0d got %b", k, running); end
            if (cnt_tick !== exp_tk) begin n_fail++; $display("FAIL resume_tick k=%0d got %b want %b", k, cnt_tick, exp_tk); end
        end
    endtask

    task automatic test_clear_priority();
        logic [1:0] exp_st;
        logic       exp_tk;
        logic       exp_cl;
        wait_tick();
        step(1);
        btn_clear = 1'b1;
        btn_pause = 1'b1;
        for (int k = 2; k <= 12; k++) begin
            step(1);
            if (k == 10) begin btn_clear = 1'b0; btn_pause = 1'b0; end
            exp_st = (k >= 8) ? 2'b00 : 2'b01;
            exp_tk = (k == 4);
            exp_cl = (k == 8);
            n_checks += 3;
            if (state !== exp_st) begin n_fail++; $display("FAIL clrpri_state k=%0d got %b want %b", k, state, exp_st); end
            if (cnt_tick !== exp_tk) begin n_fail++; $display("FAIL clrpri_tick k=%0d got %b want %b", k, cnt_tick, exp_tk); end
            if (cnt_clr !== exp_cl) begin n_fail++; $display("FAIL clrpri_clr k=%0d got %b want %b", k, cnt_clr, exp_cl); end
        end
    endtask

    task automatic test_clear_idle();
        logic exp_cl;
        step(8);
        btn_clear = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            if (k == 8) btn_clear = 1'b0;
            exp_cl = (k == 7);
            n_checks += 3;
            if (state !== 2'b00) begin n_fail++; $display("FAIL clridle_state k=%0d got %b want 00", k, state); end
            if (cnt_clr !== exp_cl) begin n_fail++; $display("FAIL clridle_clr k=%0d got %b want %b", k, cnt_clr, exp_cl); end
            if (cnt_tick !== 1'b0) begin n_fail++; $display("FAIL clridle_tick k=%0d got %b want 0", k, cnt_tick); end
        end
    endtask

    task automatic test_restart();
        logic [1:0] exp_st;
        logic       exp_tk;
        step(8);
        btn_start = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            if (k == 10) btn_start = 1'b0;
            exp_st = (k >= 7) ? 2'b01 : 2'b00;
            exp_tk = (k == 11) || (k == 15);
            n_checks += 2;
            if (state !== exp_st) begin n_fail++; $display("FAIL restart_state k=%0d got %b want %b", k, state, exp_st); end
            if (cnt_tick !== exp_tk) begin n_fail++; $display("FAIL restart_tick k=%0d got %b want %b", k, cnt_tick, exp_tk); end
        end
    endtask

`ifdef STOPWATCH_LAP_EN
    task automatic test_lap();
        cnt_val = 4'd7;
        btn_lap = 1'b1;
        step(7);
        n_checks++;
        if (lap_val !== 4'd7) begin n_fail++; $display("FAIL lap_capture got %0d want 7", lap_val); end
        cnt_val = 4'd8;
        step(1);
        n_checks++;
        if (lap_val !== 4'd7) begin n_fail++; $display("FAIL lap_hold8 got %0d want 7", lap_val); end
        cnt_val = 4'd9;
        step(1);
        n_checks++;
        if (lap_val !== 4'd7) begin n_fail++; $display("FAIL lap_hold9 got %0d want 7", lap_val); end
        btn_lap = 1'b0;
        step(8);
        n_checks++;
        if (lap_val !== 4'd7) begin n_fail++; $display("FAIL lap_hold_long got %0d want 7", lap_val); end
        cnt_val = 4'd11;
        btn_lap = 1'b1;
        step(7);
        n_checks++;
        if (lap_val !== 4'd11) begin n_fail++; $display("FAIL lap_release got %0d want 11", lap_val); end
        cnt_val = 4'd12;
        step(1);
        n_checks++;
        if (lap_val !== 4'd12) begin n_fail++; $display("FAIL lap_track12 got %0d want 12", lap_val); end
        cnt_val = 4'd13;
        step(1);
        n_checks++;
        if (lap_val !== 4'd13) begin n_fail++; $display("FAIL lap_track13 got %0d want 13", lap_val); end
        btn_lap = 1'b0;
        step(8);
    endtask
`else
    task automatic test_lap();
        logic [3:0] vals [4];
        vals = '{4'd0, 4'd9, 4'd15, 4'd3};
        for (int i = 0; i < 4; i++) begin
            cnt_val = vals[i];
            #1;
            n_checks++;
            if (lap_val !== vals[i]) begin n_fail++; $display("FAIL lap_passthru got %0d want %0d", lap_val, vals[i]); end
        end
        step(1);
    endtask
`endif

    task automatic test_reset_mid_run();
        wait_tick();
        reset = 1'b1;
        #1;
        n_checks += 4;
        if (state !== 2'b00) begin n_fail++; $display("FAIL midrst_state got %b want 00", state); end
        if (running !== 1'b0) begin n_fail++; $display("FAIL midrst_running got %b want 0", running); end
        if (cnt_tick !== 1'b0) begin n_fail++; $display("FAIL midrst_tick got %b want 0", cnt_tick); end
        if (cnt_clr !== 1'b0) begin n_fail++; $display("FAIL midrst_clr got %b want 0", cnt_clr); end
        step(2);
        reset = 1'b0;
        step(10);
        n_checks += 2;
        if (state !== 2'b00) begin n_fail++; $display("FAIL postrst_state got %b want 00", state); end
        if (cnt_tick !== 1'b0) begin n_fail++; $display("FAIL postrst_tick got %b want 0", cnt_tick); end
    endtask

    initial begin
        reset     = 1'b1;
        btn_start = 1'b0;
        btn_pause = 1'b0;
        btn_clear = 1'b0;
        btn_lap   = 1'b0;
        cnt_val   = 4'd5;
        step(3);
        test_reset();
        reset = 1'b0;
        step(2);
        test_start();
        test_pause_glitch();
        test_pause_resume();
        test_clear_priority();
        test_clear_idle();
        test_restart();
        test_lap();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
